uart_rx: RTL

- Oversampling UART receiver. Counterpart of the existing uart_tx.
- Samples the serial line on each baudpulse_in strobe, which runs at baud rate × OVERSAMPLING.
- Reconstructs 8N1-style frames, LSB first, and presents each received word with a one-cycle done strobe.
- Sits between the pad-side RX pin and the UART host logic. Shares the baud generator with uart_tx.

---
 rtl/uart_rx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver, LSB first, one-cycle result strobes.
// Define UART_RX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd/even) before the stop bit.
module uart_rx #(
   parameter int OVERSAMPLING = 8,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 sysclk_in,
   input  logic                 rst_in,
   input  logic                 baudpulse_in,
   input  logic                 rx_serial_in,
   output logic [DATA_BITS-1:0] rx_data_out,
   output logic                 rx_done_out,
   output logic                 rx_busy_out,
   output logic                 rx_frame_err_out,
   output logic                 rx_parity_err_out
);

   localparam int TW = $clog2(OVERSAMPLING);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLING / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLING - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   localparam logic          PAR_ODD  = (PARITY_ODD != 0);

`ifdef UART_RX_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] START    = 3'd1;
   localparam logic [2:0] DATA     = 3'd2;
   localparam logic [2:0] PARITY   = 3'd3;
   localparam logic [2:0] STOP     = 3'd4;
   localparam logic [2:0] BRK_WAIT = 3'd5;

   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic [2:0]           state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [BW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bad_q, par_bad_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 done_q, done_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 line;

   assign line = sync2_q;

   always_comb begin
      sync1_d   = rx_serial_in;
      sync2_d   = sync1_q;
      state_d   = state_q;
      tick_d    = tick_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      par_bad_d = par_bad_q;
      data_d    = data_q;
      done_d    = 1'b0;
      ferr_d    = 1'b0;
      perr_d    = 1'b0;

      if (baudpulse_in) begin
         case (state_q)
            IDLE: begin
               if (!line) begin
                  tick_d  = '0;
                  state_d = START;
               end
            end
            START: begin
               if (tick_q == TICK_MID) begin
                  if (line) begin
                     state_d = IDLE;
                  end else begin
                     tick_d    = '0;
                     bit_idx_d = '0;
                     par_bad_d = 1'b0;
                     state_d   = DATA;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            DATA: begin
               if (tick_q == TICK_END) begin
                  shift_d[bit_idx_q] = line;
                  tick_d             = '0;
                  bit_idx_d          = bit_idx_q + BW'(1);
                  if (bit_idx_q == BIT_LAST) begin
                     state_d = PAR_EN ? PARITY : STOP;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            PARITY: begin
               if (tick_q == TICK_END) begin
                  par_bad_d = line ^ (^shift_q) ^ PAR_ODD;
                  tick_d    = '0;
                  state_d   = STOP;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            STOP: begin
               if (tick_q == TICK_END) begin
                  tick_d = '0;
                  // A low stop bit wins over any parity verdict.
                  if (line) begin
                     if (PAR_EN && par_bad_q) begin
                        perr_d = 1'b1;
                     end else begin
                        data_d = shift_q;
                        done_d = 1'b1;
                     end
                     state_d = IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = BRK_WAIT;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            BRK_WAIT: begin
               if (line) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge sysclk_in) begin
      if (rst_in) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
         data_q    <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         par_bad_q <= par_bad_d;
         data_q    <= data_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
         perr_q    <= perr_d;
      end
   end

   assign rx_data_out       = data_q;
   assign rx_done_out       = done_q;
   assign rx_busy_out       = (state_q != IDLE);
   assign rx_frame_err_out  = ferr_q;
   assign rx_parity_err_out = perr_q;

endmodule
